// File: rtl/alu_pkg.sv
// Shared ALU op encodings, FSM state enum and slice control decode.
// Pure types/functions, no latency.
// No flow control here.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0110,
        OP_SLT = 4'b0111,
        OP_NOR = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic       ainv;
        logic       binv;
        logic [1:0] sel;
        logic       legal;
        logic       arith;
        logic       slt;
    } slice_ctrl_t;

    function automatic slice_ctrl_t decode_op(input logic [3:0] op);
        slice_ctrl_t c;
        c = '{ainv: 1'b0, binv: 1'b0, sel: 2'b00, legal: 1'b0, arith: 1'b0, slt: 1'b0};
        case (op)
            OP_AND: c = '{ainv: 1'b0, binv: 1'b0, sel: 2'b00, legal: 1'b1, arith: 1'b0, slt: 1'b0};
            OP_OR:  c = '{ainv: 1'b0, binv: 1'b0, sel: 2'b01, legal: 1'b1, arith: 1'b0, slt: 1'b0};
            OP_ADD: c = '{ainv: 1'b0, binv: 1'b0, sel: 2'b10, legal: 1'b1, arith: 1'b1, slt: 1'b0};
            OP_SUB: c = '{ainv: 1'b0, binv: 1'b1, sel: 2'b10, legal: 1'b1, arith: 1'b1, slt: 1'b0};
            OP_SLT: c = '{ainv: 1'b0, binv: 1'b1, sel: 2'b10, legal: 1'b1, arith: 1'b1, slt: 1'b1};
            OP_NOR: c = '{ainv: 1'b1, binv: 1'b1, sel: 2'b00, legal: 1'b1, arith: 1'b0, slt: 1'b0};
            default: c = '{ainv: 1'b0, binv: 1'b0, sel: 2'b00, legal: 1'b0, arith: 1'b0, slt: 1'b0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ALU_1bit_SET.sv
// One-bit ALU slice with operand inversion, full adder and Set output.
// Purely combinational, zero latency.
// No flow control.
module ALU_1bit_SET (
    input  logic       a,
    input  logic       b,
    input  logic       Ainvert,
    input  logic       Binvert,
    input  logic       CarryIn,
    input  logic [1:0] Operation,
    input  logic       Less,
    output logic       Result,
    output logic       CarryOut,
    output logic       Set
);
    logic aa;
    logic bb;
    logic sum;

    assign aa       = a ^ Ainvert;
    assign bb       = b ^ Binvert;
    assign sum      = aa ^ bb ^ CarryIn;
    assign CarryOut = (aa & bb) | (aa & CarryIn) | (bb & CarryIn);
    assign Set      = sum;

    always_comb begin
        Result = 1'b0;
        case (Operation)
            2'b00: Result = aa & bb;
            2'b01: Result = aa | bb;
            2'b10: Result = sum;
            2'b11: Result = Less;
            default: Result = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU: one slice per cycle, LSB first, over a latched request.
// Latency WIDTH+1 cycles from acceptance to out_valid.
// in_ready only in IDLE; result held in DONE until out_ready, one-cycle bubble after.
module serial_alu_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);

    state_e            state;
    logic [CW-1:0]     cnt;
    logic              carry;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [3:0]        op_q;
    logic [WIDTH-1:0]  res_q;

    slice_ctrl_t       ctrl;
    logic              slice_cin;
    logic              slice_res;
    logic              slice_cout;
    logic              slice_set;
    logic              last_bit;
    logic              v_bit;
    logic [WIDTH-1:0]  shift_nxt;
    logic [WIDTH-1:0]  fin_result;

    assign ctrl      = decode_op(op_q);
    // Bit 0 takes Binvert as carry-in so SUB/SLT form a + ~b + 1.
    assign slice_cin = (cnt == '0) ? ctrl.binv : carry;
    assign last_bit  = (cnt == CW'(WIDTH - 1));
    assign v_bit     = slice_cin ^ slice_cout;
    assign shift_nxt = {slice_res, res_q[WIDTH-1:1]};

    ALU_1bit_SET u_slice (
        .a         (a_q[cnt]),
        .b         (b_q[cnt]),
        .Ainvert   (ctrl.ainv),
        .Binvert   (ctrl.binv),
        .CarryIn   (slice_cin),
        .Operation (ctrl.sel),
        .Less      (1'b0),
        .Result    (slice_res),
        .CarryOut  (slice_cout),
        .Set       (slice_set)
    );

    always_comb begin
        fin_result = shift_nxt;
        if (!ctrl.legal) begin
            fin_result = '0;
        end else if (ctrl.slt) begin
            fin_result = {{(WIDTH-1){1'b0}}, slice_set ^ v_bit};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            res_q     <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= b;
                        op_q     <= op;
                        cnt      <= '0;
                        carry    <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    carry <= slice_cout;
                    cnt   <= cnt + CW'(1);
                    res_q <= shift_nxt;
                    if (last_bit) begin
                        res_q     <= fin_result;
                        zero      <= (fin_result == '0);
                        overflow  <= ctrl.arith & v_bit;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign result = res_q;

endmodule
